alu_arbiter: RTL and testbench

Shares the single combinational RV32I ALU between two requesters: requester 0 is the core execute stage and requester 1 is the auxiliary port used by the debug/coprocessor path. The arbiter selects one request per cycle with round-robin or fixed priority and drives the selected operands onto the ALU. It registers the ALU result and branch flag into a single response slot tagged with the requester id, and holds that slot under valid/ready backpressure.

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational RV32I ALU.
// The result is captured into a single response slot tagged with the requester id.
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int FAIR = 1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [6:0]      r0_opcode,
    input  logic [3:0]      r0_alu_ctrl,
    input  logic [XLEN-1:0] r0_src_a,
    input  logic [XLEN-1:0] r0_src_b,

    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [6:0]      r1_opcode,
    input  logic [3:0]      r1_alu_ctrl,
    input  logic [XLEN-1:0] r1_src_a,
    input  logic [XLEN-1:0] r1_src_b,

    output logic [6:0]      alu_opcode,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_src_a,
    output logic [XLEN-1:0] alu_src_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_branch,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_branch
);

    localparam logic [6:0] IDLE_OPCODE = 7'b0110011;
    localparam logic [3:0] IDLE_CTRL   = 4'b0000;

    logic            rsp_valid_q,  rsp_valid_d;
    logic            rsp_id_q,     rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_branch_q, rsp_branch_d;
    logic            last_grant_q, last_grant_d;

    logic can_issue;
    logic gnt0;
    logic gnt1;

    assign can_issue = ~rsp_valid_q | rsp_ready;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && can_issue) begin
            if (r0_valid && r1_valid) begin
                // Round-robin favours whoever did not win the last handshake.
                if ((FAIR != 0) && (last_grant_q == 1'b0)) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (r0_valid) begin
                gnt0 = 1'b1;
            end else if (r1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    // Without a grant the ALU sees add 0 + 0 rather than stale operands.
    always_comb begin
        alu_opcode = IDLE_OPCODE;
        alu_ctrl   = IDLE_CTRL;
        alu_src_a  = '0;
        alu_src_b  = '0;
        if (gnt0) begin
            alu_opcode = r0_opcode;
            alu_ctrl   = r0_alu_ctrl;
            alu_src_a  = r0_src_a;
            alu_src_b  = r0_src_b;
        end else if (gnt1) begin
            alu_opcode = r1_opcode;
            alu_ctrl   = r1_alu_ctrl;
            alu_src_a  = r1_src_a;
            alu_src_b  = r1_src_b;
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_branch_d = rsp_branch_q;
        last_grant_d = last_grant_q;
        if (gnt0 || gnt1) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt1;
            rsp_result_d = alu_result;
            rsp_branch_d = alu_branch;
            last_grant_d = gnt1;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_branch_q <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_branch_q <= rsp_branch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_branch = rsp_branch_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a scoreboard queue is filled by the stimulus
// and drained by a monitor whenever a response is consumed.
module tb_alu_arbiter;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid, rsp_ready;
    logic [6:0]  r0_opcode, r1_opcode;
    logic [3:0]  r0_alu_ctrl, r1_alu_ctrl;
    logic [31:0] r0_src_a, r0_src_b, r1_src_a, r1_src_b;

    logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_branch;
    logic [6:0]  alu_opcode;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_src_a, alu_src_b, alu_result, rsp_result;
    logic        alu_branch;

    logic        fp_r0_ready, fp_r1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_branch;
    logic [6:0]  fp_alu_opcode;
    logic [3:0]  fp_alu_ctrl;
    logic [31:0] fp_alu_src_a, fp_alu_src_b, fp_alu_result, fp_rsp_result;
    logic        fp_alu_branch;

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_model(logic [6:0] op, logic [3:0] ctrl,
                                              logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (ctrl)
            C_ADD:   r = a + b;
            C_SUB:   r = a - b;
            default: r = a & b;
        endcase
        return {r, (op == OP_BR) && (a == b)};
    endfunction

    assign {alu_result, alu_branch}       = alu_model(alu_opcode, alu_ctrl, alu_src_a, alu_src_b);
    assign {fp_alu_result, fp_alu_branch} = alu_model(fp_alu_opcode, fp_alu_ctrl, fp_alu_src_a, fp_alu_src_b);

    alu_arbiter #(.XLEN(32), .FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode),
        .r0_alu_ctrl(r0_alu_ctrl), .r0_src_a(r0_src_a), .r0_src_b(r0_src_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode),
        .r1_alu_ctrl(r1_alu_ctrl), .r1_src_a(r1_src_a), .r1_src_b(r1_src_b),
        .alu_opcode(alu_opcode), .alu_ctrl(alu_ctrl),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_result(alu_result), .alu_branch(alu_branch),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_branch(rsp_branch)
    );

    alu_arbiter #(.XLEN(32), .FAIR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_opcode(r0_opcode),
        .r0_alu_ctrl(r0_alu_ctrl), .r0_src_a(r0_src_a), .r0_src_b(r0_src_b),
        .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_opcode(r1_opcode),
        .r1_alu_ctrl(r1_alu_ctrl), .r1_src_a(r1_src_a), .r1_src_b(r1_src_b),
        .alu_opcode(fp_alu_opcode), .alu_ctrl(fp_alu_ctrl),
        .alu_src_a(fp_alu_src_a), .alu_src_b(fp_alu_src_b),
        .alu_result(fp_alu_result), .alu_branch(fp_alu_branch),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_result(fp_rsp_result), .rsp_branch(fp_rsp_branch)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        br;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic set_r0(logic v, logic [6:0] op, logic [3:0] c, logic [31:0] a, logic [31:0] b);
        r0_valid = v; r0_opcode = op; r0_alu_ctrl = c; r0_src_a = a; r0_src_b = b;
    endtask

    task automatic set_r1(logic v, logic [6:0] op, logic [3:0] c, logic [31:0] a, logic [31:0] b);
        r1_valid = v; r1_opcode = op; r1_alu_ctrl = c; r1_src_a = a; r1_src_b = b;
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    // Monitor: a response is consumed when valid and ready meet at the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_rsp actual id=%0d result=%0h required=none",
                             rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
                    chk("sb_rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
                    chk("sb_rsp_branch", {63'd0, rsp_branch}, {63'd0, e.br});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rr_res [4];
    logic        rr_id  [4];

    initial begin
        rr_res[0] = 32'd3;   rr_id[0] = 1'b0;
        rr_res[1] = 32'd6;   rr_id[1] = 1'b1;
        rr_res[2] = 32'd123; rr_id[2] = 1'b0;
        rr_res[3] = 32'hFFFF_FFF6; rr_id[3] = 1'b1;

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_r0(1'b1, OP_R, C_ADD, 32'd5, 32'd7);
        set_r1(1'b0, OP_R, C_ADD, 32'd0, 32'd0);

        // Reset held for two edges with r0 requesting.
        @(negedge clk);
        chk("rst_r0_ready", {63'd0, r0_ready}, 64'd0);
        chk("rst_r1_ready", {63'd0, r1_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        chk("rst_rsp_branch", {63'd0, rsp_branch}, 64'd0);
        chk("rst_alu_opcode", {57'd0, alu_opcode}, {57'd0, OP_R});
        chk("rst_alu_src_a", {32'd0, alu_src_a}, 64'd0);
        chk("rst_fp_r0_ready", {63'd0, fp_r0_ready}, 64'd0);
        drive_slot();
        rst_n = 1'b1;

        // First cycle after release: r0 granted, add 5 + 7.
        @(negedge clk);
        chk("rel_r0_ready", {63'd0, r0_ready}, 64'd1);
        chk("rel_r1_ready", {63'd0, r1_ready}, 64'd0);
        chk("add_alu_src_a", {32'd0, alu_src_a}, 64'd5);
        chk("add_alu_src_b", {32'd0, alu_src_b}, 64'd7);
        sb.push_back('{id: 1'b0, res: 32'd12, br: 1'b0});
        drive_slot();
        set_r0(1'b0, OP_R, C_ADD, 32'd0, 32'd0);
        set_r1(1'b1, OP_BR, C_SUB, 32'd3, 32'd3);

        @(negedge clk);
        chk("add_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("add_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("add_rsp_result", {32'd0, rsp_result}, 64'd12);
        chk("beq_r1_ready", {63'd1, r1_ready}, {63'd1, 1'b1});
        sb.push_back('{id: 1'b1, res: 32'd0, br: 1'b1});
        drive_slot();
        rsp_ready = 1'b0;
        set_r0(1'b1, OP_R, C_ADD, 32'd1, 32'd1);
        set_r1(1'b1, OP_R, C_ADD, 32'd20, 32'd22);

        // Backpressure: slot holds the beq response for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("bp_r0_ready", {63'd0, r0_ready}, 64'd0);
            chk("bp_r1_ready", {63'd0, r1_ready}, 64'd0);
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_id", {63'd0, rsp_id}, 64'd1);
            chk("bp_rsp_result", {32'd0, rsp_result}, 64'd0);
            chk("bp_rsp_branch", {63'd0, rsp_branch}, 64'd1);
            chk("bp_alu_src_a", {32'd0, alu_src_a}, 64'd0);
            chk("bp_alu_opcode", {57'd0, alu_opcode}, {57'd0, OP_R});
            drive_slot();
        end
        rsp_ready = 1'b1;

        // Drain and new grant in the same cycle; r1 won last, so r0 wins now.
        @(negedge clk);
        chk("resume_r0_ready", {63'd0, r0_ready}, 64'd1);
        chk("resume_r1_ready", {63'd0, r1_ready}, 64'd0);
        sb.push_back('{id: 1'b0, res: 32'd2, br: 1'b0});
        drive_slot();
        set_r0(1'b0, OP_R, C_ADD, 32'd0, 32'd0);

        @(negedge clk);
        chk("nobubble_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("nobubble_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("r1_pending_ready", {63'd0, r1_ready}, 64'd1);
        sb.push_back('{id: 1'b1, res: 32'd42, br: 1'b0});
        drive_slot();
        set_r0(1'b1, OP_R, C_ADD, 32'd1, 32'd2);
        set_r1(1'b1, OP_R, C_SUB, 32'd10, 32'd4);

        // Both valid: round-robin alternates, fixed-priority instance always picks r0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_r0_ready", {63'd0, r0_ready}, {63'd0, ~rr_id[i]});
            chk("rr_r1_ready", {63'd0, r1_ready}, {63'd0, rr_id[i]});
            chk("fp_r0_ready", {63'd0, fp_r0_ready}, 64'd1);
            chk("fp_r1_ready", {63'd0, fp_r1_ready}, 64'd0);
            sb.push_back('{id: rr_id[i], res: rr_res[i], br: 1'b0});
            drive_slot();
            case (i)
                0: set_r0(1'b1, OP_R, C_ADD, 32'd100, 32'd23);
                1: set_r1(1'b1, OP_R, C_SUB, 32'd50, 32'd60);
                2: set_r0(1'b1, OP_R, C_ADD, 32'd7, 32'd8);
                default: begin
                    set_r0(1'b0, OP_R, C_ADD, 32'd0, 32'd0);
                    set_r1(1'b0, OP_R, C_ADD, 32'd0, 32'd0);
                end
            endcase
        end

        @(negedge clk);
        drive_slot();
        rsp_ready = 1'b0;
        set_r0(1'b1, OP_R, C_ADD, 32'd3, 32'd3);

        // Reset while a response is pending: it must be discarded.
        @(negedge clk);
        chk("mid_r0_ready", {63'd0, r0_ready}, 64'd1);
        drive_slot();
        set_r0(1'b0, OP_R, C_ADD, 32'd0, 32'd0);
        @(negedge clk);
        chk("mid_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("mid_rsp_result", {32'd0, rsp_result}, 64'd6);
        drive_slot();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_r1(1'b1, OP_R, C_ADD, 32'd9, 32'd9);
        @(negedge clk);
        chk("midrst_r1_ready", {63'd0, r1_ready}, 64'd0);
        chk("midrst_alu_src_a", {32'd0, alu_src_a}, 64'd0);
        drive_slot();
        rst_n = 1'b1;
        set_r1(1'b0, OP_R, C_ADD, 32'd0, 32'd0);
        @(negedge clk);
        chk("postrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("postrst_rsp_result", {32'd0, rsp_result}, 64'd0);
        chk("postrst_rsp_id", {63'd0, rsp_id}, 64'd0);
        @(negedge clk);
        chk("postrst_idle_valid", {63'd0, rsp_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
